// File: rtl/pe_pkg.sv
// pe_pkg: constants shared by the PE, its feeder and its output drain, plus the drain state type
package pe_pkg;
  localparam int SUM_W = 25;
  localparam int NSUM = 61;
  localparam int OFM_W = 1526;
  localparam int IDX_W = 6;
  typedef enum logic {IDLE, SEND} drain_state_t;
endpackage

// File: rtl/ofm_requant.sv
// ofm_requant: sum[SUM_W], shift[5] -> data[8]; unsigned right shift then saturate to 255
module ofm_requant import pe_pkg::*; (
  input  logic [SUM_W-1:0] sum,
  input  logic [4:0]       shift,
  output logic [7:0]       data
);
  logic [SUM_W-1:0] s;
  always_comb begin
    s = sum >> shift;
    data = |s[SUM_W-1:8] ? 8'hff : s[7:0];
  end
endmodule

// File: rtl/pe_ofm_drain.sv
// pe_ofm_drain: captures the PE ofm bus on start, streams nvalid sums (raw + requantized) over valid/ready, pulses done
module pe_ofm_drain import pe_pkg::*; #(
  parameter int SUM_W = pe_pkg::SUM_W,
  parameter int NSUM  = pe_pkg::NSUM,
  parameter int OFM_W = pe_pkg::OFM_W,
  parameter int IDX_W = pe_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OFM_W-1:0] ofm,
  input  logic             start,
  input  logic [6:0]       nvalid,
  input  logic [4:0]       shift,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_raw,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done
);
  drain_state_t     state;
  logic [SUM_W-1:0] mem [NSUM];
  logic [4:0]       shift_q;
  logic [IDX_W:0]   cnt, cnt_n;
  logic [IDX_W-1:0] idx;
  logic             send, last, xfer;
  logic             unused_msb;
  assign unused_msb = ofm[OFM_W-1];
  always_comb begin
    send = state == SEND;
    last = send && ({1'b0, idx} == cnt - 1'b1);
    xfer = send && out_ready;
    cnt_n = nvalid > 7'(NSUM) ? 7'(NSUM) : nvalid;
  end
  assign busy = send;
  assign out_valid = send;
  assign out_idx = idx;
  assign out_last = last;
  assign out_raw = send ? mem[idx] : '0;
  ofm_requant u_requant (.sum(out_raw), .shift(shift_q), .data(out_data));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shift_q <= '0;
      cnt <= '0;
      idx <= '0;
      done <= 1'b0;
      for (int i = 0; i < NSUM; i++) mem[i] <= '0;
    end else begin
      done <= (!send && start && cnt_n == '0) || (xfer && last);
      if (!send && start) begin
        for (int i = 0; i < NSUM; i++) mem[i] <= ofm[i*SUM_W +: SUM_W];
        shift_q <= shift;
        cnt <= cnt_n;
        idx <= '0;
        state <= cnt_n == '0 ? IDLE : SEND;
      end else if (xfer) begin
        idx <= last ? '0 : idx + 1'b1;
        state <= last ? IDLE : SEND;
      end
    end
  end
endmodule

// File: tb/tb_pe_ofm_drain.sv
// tb_pe_ofm_drain: scoreboard bench for pe_ofm_drain
module tb_pe_ofm_drain;
  localparam int SUM_W = 25;
  localparam int NSUM = 61;
  localparam int OFM_W = 1526;
  localparam int IDX_W = 6;
  typedef struct packed {
    logic [SUM_W-1:0] raw;
    logic [7:0]       data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } beat_t;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [OFM_W-1:0] ofm = '0;
  logic [6:0] nvalid = '0;
  logic [4:0] shift = '0;
  logic busy, out_valid, out_last, done;
  logic [SUM_W-1:0] out_raw;
  logic [7:0] out_data;
  logic [IDX_W-1:0] out_idx;
  int total = 0, bad = 0, edges = 0, n0 = 0, vcnt = 0, bcnt = 0, done_cnt = 0, done_rel = 0;
  beat_t exp_q[$], got_q[$];
  int got_rel[$];
  logic [SUM_W-1:0] slot [NSUM];

  pe_ofm_drain dut (
    .clk(clk), .rst(rst), .ofm(ofm), .start(start), .nvalid(nvalid), .shift(shift),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_raw(out_raw),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) vcnt++;
      if (busy) bcnt++;
      if (out_valid && out_ready) begin
        got_q.push_back({out_raw, out_data, out_idx, out_last});
        got_rel.push_back(edges - n0 + 1);
      end
      if (done) begin
        done_cnt++;
        done_rel = edges - n0 + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] quant(input logic [SUM_W-1:0] s, input int sh);
    longint v;
    v = longint'(s);
    for (int i = 0; i < sh; i++) v = v / 2;
    return v > 255 ? 8'd255 : 8'(v);
  endfunction

  task automatic rand_slots;
    for (int i = 0; i < NSUM; i++) slot[i] = SUM_W'($urandom);
  endtask

  task automatic set_ofm;
    for (int i = 0; i < NSUM; i++) ofm[i*SUM_W +: SUM_W] = slot[i];
    ofm[OFM_W-1] = 1'($urandom);
  endtask

  task automatic push_exp(input int nv);
    int c;
    c = nv > NSUM ? NSUM : nv;
    for (int i = 0; i < c; i++)
      exp_q.push_back({slot[i], quant(slot[i], int'(shift)), IDX_W'(i), i == c - 1});
  endtask

  task automatic clear_sb;
    exp_q.delete();
    got_q.delete();
    got_rel.delete();
    vcnt = 0;
    bcnt = 0;
  endtask

  task automatic pulse_start;
    start = 1;
    @(posedge clk);
    #1;
    n0 = edges;
    start = 0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk);
      ok = done_cnt > d0;
    end
    #1;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({busy, out_valid, out_raw, out_data, out_idx, out_last, done} !== '0) begin
      bad++;
      $display("FAIL reset_async got=%0h exp=0", {busy, out_valid, out_raw, out_data, out_idx, out_last, done});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    total++;
    if ({busy, out_valid, out_raw, out_data, out_idx, out_last, done} !== '0) begin
      bad++;
      $display("FAIL reset_idle got=%0h exp=0", {busy, out_valid, out_raw, out_data, out_idx, out_last, done});
    end
  endtask

  task automatic test_basic;
    bit ok;
    beat_t e, g;
    clear_sb;
    rand_slots;
    slot[0] = 25'd10;
    slot[1] = 25'd300;
    slot[2] = 25'h1ffffff;
    set_ofm;
    nvalid = 7'd3;
    shift = 5'd0;
    out_ready = 1;
    exp_q.push_back({25'd10, 8'd10, 6'd0, 1'b0});
    exp_q.push_back({25'd300, 8'd255, 6'd1, 1'b0});
    exp_q.push_back({25'h1ffffff, 8'd255, 6'd2, 1'b1});
    pulse_start;
    wait_done(20, ok);
    total++;
    if (!ok || done_rel != 4) begin
      bad++;
      $display("FAIL basic_done_cycle got=%0d exp=4 seen=%0d", done_rel, ok);
    end
    for (int i = 0; i < got_rel.size(); i++) begin
      total++;
      if (got_rel[i] != i + 1) begin
        bad++;
        $display("FAIL basic_beat_cycle beat=%0d got=%0d exp=%0d", i, got_rel[i], i + 1);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL basic_beat got=%h exp=%h", g, e);
      end
    end
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL basic_extra_beats got=%0d exp=0", got_q.size());
    end
  endtask

  task automatic test_shift;
    int sh_t[3] = '{2, 3, 31};
    int ex_t[3] = '{250, 125, 0};
    bit ok;
    beat_t e, g;
    for (int k = 0; k < 3; k++) begin
      clear_sb;
      rand_slots;
      slot[0] = 25'd1000;
      set_ofm;
      nvalid = 7'd1;
      shift = 5'(sh_t[k]);
      out_ready = 1;
      e = {25'd1000, 8'(ex_t[k]), 6'd0, 1'b1};
      pulse_start;
      wait_done(10, ok);
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      total++;
      if (!ok || g !== e || got_q.size() != 0) begin
        bad++;
        $display("FAIL shift_%0d got=%h exp=%h done=%0d", sh_t[k], g, e, ok);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    beat_t e, g, b1;
    clear_sb;
    rand_slots;
    set_ofm;
    nvalid = 7'd3;
    shift = 5'($urandom_range(0, 8));
    out_ready = 1;
    push_exp(3);
    b1 = exp_q[1];
    pulse_start;
    @(posedge clk);
    #1;
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_raw, out_data, out_idx, out_last} !== {1'b1, b1}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, {out_valid, out_raw, out_data, out_idx, out_last}, {1'b1, b1});
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    wait_done(20, ok);
    total++;
    if (!ok || done_rel != 7) begin
      bad++;
      $display("FAIL bp_done_cycle got=%0d exp=7 seen=%0d", done_rel, ok);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL bp_beat got=%h exp=%h", g, e);
      end
    end
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL bp_extra_beats got=%0d exp=0", got_q.size());
    end
  endtask

  task automatic test_nvalid_zero;
    bit ok;
    clear_sb;
    rand_slots;
    set_ofm;
    nvalid = 7'd0;
    out_ready = 1;
    pulse_start;
    wait_done(10, ok);
    total++;
    if (!ok || done_rel != 1) begin
      bad++;
      $display("FAIL zero_done_cycle got=%0d exp=1 seen=%0d", done_rel, ok);
    end
    repeat (2) @(negedge clk);
    total++;
    if (vcnt != 0 || bcnt != 0 || got_q.size() != 0 || done !== 1'b0) begin
      bad++;
      $display("FAIL zero_quiet valid=%0d busy=%0d beats=%0d done=%b exp=0/0/0/0", vcnt, bcnt, got_q.size(), done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full;
    bit ok;
    beat_t e, g;
    clear_sb;
    rand_slots;
    set_ofm;
    nvalid = 7'd100;
    shift = 5'($urandom_range(0, 12));
    out_ready = 1;
    push_exp(100);
    pulse_start;
    wait_done(100, ok);
    total++;
    if (!ok || done_rel != 62 || got_q.size() != 61) begin
      bad++;
      $display("FAIL full_count done_cycle=%0d beats=%0d exp=62/61", done_rel, got_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL full_beat got=%h exp=%h", g, e);
      end
    end
  endtask

  task automatic test_ignored_start;
    bit ok;
    int d0;
    beat_t e, g;
    clear_sb;
    rand_slots;
    set_ofm;
    nvalid = 7'd5;
    shift = 5'd1;
    out_ready = 1;
    push_exp(5);
    pulse_start;
    @(posedge clk);
    #1;
    rand_slots;
    set_ofm;
    nvalid = 7'd2;
    shift = 5'd0;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    rand_slots;
    set_ofm;
    repeat (2) @(posedge clk);
    #1;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    d0 = done_cnt;
    wait_done(10, ok);
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (!ok || done_cnt != d0 + 1 || got_q.size() != 5 || vcnt != 5) begin
      bad++;
      $display("FAIL ign_count done=%0d beats=%0d valid=%0d exp=1/5/5", done_cnt - d0, got_q.size(), vcnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL ign_beat got=%h exp=%h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    beat_t e, g;
    clear_sb;
    rand_slots;
    set_ofm;
    nvalid = 7'd2;
    shift = 5'd4;
    out_ready = 1;
    push_exp(2);
    pulse_start;
    repeat (2) @(posedge clk);
    #1;
    rand_slots;
    set_ofm;
    push_exp(2);
    start = 1;
    @(posedge clk);
    #1;
    n0 = edges;
    start = 0;
    wait_done(10, ok);
    total++;
    if (!ok || done_rel != 3 || got_q.size() != 4) begin
      bad++;
      $display("FAIL b2b_count done_cycle=%0d beats=%0d exp=3/4", done_rel, got_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL b2b_beat got=%h exp=%h", g, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int d0;
    beat_t e, g;
    clear_sb;
    rand_slots;
    set_ofm;
    nvalid = 7'd3;
    shift = 5'd2;
    out_ready = 1;
    push_exp(3);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    pulse_start;
    @(posedge clk);
    #2;
    d0 = done_cnt;
    rst = 1;
    #1;
    total++;
    if ({busy, out_valid, out_raw, out_data, out_idx, out_last, done} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs got=%0h exp=0", {busy, out_valid, out_raw, out_data, out_idx, out_last, done});
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0 || got_q.size() != 1) begin
      bad++;
      $display("FAIL rstmid_discard done=%0d beats=%0d exp=0/1", done_cnt - d0, got_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL rstmid_beat0 got=%h exp=%h", g, e);
      end
    end
    clear_sb;
    rand_slots;
    set_ofm;
    push_exp(3);
    pulse_start;
    wait_done(20, ok);
    total++;
    if (!ok || done_rel != 4) begin
      bad++;
      $display("FAIL rstmid_restart_done got=%0d exp=4 seen=%0d", done_rel, ok);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL rstmid_restart_beat got=%h exp=%h", g, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_shift;
    test_backpressure;
    test_nvalid_zero;
    test_full;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
